pe_column_n: RTL and testbench

Parametrised systolic processing-element column, the successor to the fixed 9-PE column. It holds `NUM_PE` stationary weights and accepts one aligned feature-map vector plus an incoming partial sum per cycle. It skews the vector internally, so callers no longer drive per-PE left/right enables. It emits `i_psum + Σ w[k]·fmap[k]` down the column after a fixed latency, and sits between the fmap line buffer and the psum accumulator of the array.

---
 rtl/pe_column_pkg.sv | 22 ++
 rtl/pe_mac_stage.sv | 47 ++++
 rtl/pe_column_n.sv | 164 ++++++++++++++++
 tb/tb_pe_column_n.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_column_pkg.sv
// Shared types and helpers for the parametrised systolic PE column.
// Products are formed at a fixed wide width and truncated by the caller.
package pe_column_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } pe_col_state_t;

    // Operands up to 32 bits wide; the 64-bit product is exact for them.
    localparam int PROD_IN_W  = 32;
    localparam int PROD_MAX_W = 64;

    function automatic logic signed [PROD_MAX_W-1:0] sext_prod(
        input logic signed [PROD_IN_W-1:0] a,
        input logic signed [PROD_IN_W-1:0] b
    );
        return PROD_MAX_W'(a) * PROD_MAX_W'(b);
    endfunction

endpackage

// File: rtl/pe_mac_stage.sv
// One processing element: stationary weight, signed MAC, registered psum.
// The psum register holds its value whenever no valid psum arrives.
module pe_mac_stage
    import pe_column_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         i_clk,
    input  logic                         i_rest,
    input  logic                         i_w_we,
    input  logic signed [DATA_WIDTH-1:0] i_w_data,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_fmap,
    input  logic signed [ACC_WIDTH-1:0]  i_psum,
    output logic                         o_valid,
    output logic signed [ACC_WIDTH-1:0]  o_psum
);

    logic signed [DATA_WIDTH-1:0] r_w;
    logic                         r_valid;
    logic signed [ACC_WIDTH-1:0]  r_psum;
    logic signed [ACC_WIDTH-1:0]  w_prod;

    assign w_prod = ACC_WIDTH'(sext_prod(PROD_IN_W'(r_w),
                                         PROD_IN_W'(i_fmap)));

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_w     <= '0;
            r_valid <= 1'b0;
            r_psum  <= '0;
        end else begin
            if (i_w_we) begin
                r_w <= i_w_data;
            end
            r_valid <= i_valid;
            if (i_valid) begin
                r_psum <= i_psum + w_prod;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_psum  = r_psum;

endmodule

// File: rtl/pe_column_n.sv
// Systolic PE column: weight-load FSM, input skew, NUM_PE MAC stages and
// a final output register, so a vector accepted at edge t appears at t+NUM_PE.
module pe_column_n
    import pe_column_pkg::*;
#(
    parameter int NUM_PE     = 9,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         i_clk,
    input  logic                         i_rest,
    input  logic                         i_w_load,
    input  logic [DATA_WIDTH-1:0]        i_w_data,
    output logic                         o_w_err,
    output logic                         o_ready,
    input  logic                         i_valid,
    input  logic [NUM_PE*DATA_WIDTH-1:0] i_fmap,
    input  logic [ACC_WIDTH-1:0]         i_psum,
    output logic                         o_valid,
    output logic [ACC_WIDTH-1:0]         o_psum,
    output logic                         o_busy
);

    localparam int CNT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    pe_col_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_widx;
    logic w_wr, w_err_nxt, w_acc;
    logic r_err, r_busy, r_out_valid;
    logic signed [ACC_WIDTH-1:0] r_out_psum;

    logic signed [DATA_WIDTH-1:0] w_fin  [NUM_PE];
    logic signed [DATA_WIDTH-1:0] w_lane [NUM_PE];
    logic signed [ACC_WIDTH-1:0]  w_psum [NUM_PE];
    logic [NUM_PE-1:0] w_vld;
    logic [NUM_PE-1:0] w_we;

    assign w_acc = i_valid & (r_state == READY);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_widx      = r_cnt;
        w_wr        = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            EMPTY, LOADING: begin
                if (i_w_load) begin
                    w_wr = 1'b1;
                    if (r_cnt == CNT_W'(NUM_PE - 1)) begin
                        w_state_nxt = READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = LOADING;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            READY: begin
                // An accepted vector takes priority over a reload request.
                if (i_w_load) begin
                    if (r_busy | w_acc) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_wr        = 1'b1;
                        w_widx      = '0;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = LOADING;
                    end
                end
            end
            default: begin
                w_state_nxt = EMPTY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            r_state     <= EMPTY;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_acc | (|w_vld[NUM_PE-2:0]);
            r_out_valid <= w_vld[NUM_PE-1];
            if (w_vld[NUM_PE-1]) begin
                r_out_psum <= w_psum[NUM_PE-1];
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_PE; k++) begin : g_pe
            assign w_fin[k] = i_fmap[k*DATA_WIDTH +: DATA_WIDTH];
            assign w_we[k]  = w_wr & (w_widx == CNT_W'(k));

            if (k == 0) begin : g_noskew
                assign w_lane[k] = w_fin[k];
            end else begin : g_skew
                logic signed [DATA_WIDTH-1:0] r_sk [k];
                always_ff @(posedge i_clk) begin
                    if (i_rest) begin
                        for (int d = 0; d < k; d++) begin
                            r_sk[d] <= '0;
                        end
                    end else begin
                        r_sk[0] <= w_fin[k];
                        for (int d = 1; d < k; d++) begin
                            r_sk[d] <= r_sk[d-1];
                        end
                    end
                end
                assign w_lane[k] = r_sk[k-1];
            end

            if (k == 0) begin : g_head
                pe_mac_stage #(
                    .DATA_WIDTH(DATA_WIDTH),
                    .ACC_WIDTH (ACC_WIDTH)
                ) u_stage (
                    .i_clk   (i_clk),
                    .i_rest  (i_rest),
                    .i_w_we  (w_we[k]),
                    .i_w_data(i_w_data),
                    .i_valid (w_acc),
                    .i_fmap  (w_lane[k]),
                    .i_psum  (i_psum),
                    .o_valid (w_vld[k]),
                    .o_psum  (w_psum[k])
                );
            end else begin : g_body
                pe_mac_stage #(
                    .DATA_WIDTH(DATA_WIDTH),
                    .ACC_WIDTH (ACC_WIDTH)
                ) u_stage (
                    .i_clk   (i_clk),
                    .i_rest  (i_rest),
                    .i_w_we  (w_we[k]),
                    .i_w_data(i_w_data),
                    .i_valid (w_vld[k-1]),
                    .i_fmap  (w_lane[k]),
                    .i_psum  (w_psum[k-1]),
                    .o_valid (w_vld[k]),
                    .o_psum  (w_psum[k])
                );
            end
        end
    endgenerate

    assign o_w_err = r_err;
    assign o_ready = (r_state == READY);
    assign o_busy  = r_busy;
    assign o_valid = r_out_valid;
    assign o_psum  = r_out_psum;

endmodule

// File: tb/tb_pe_column_n.sv
// Scoreboard bench for pe_column_n with NUM_PE=3, DATA_WIDTH=8, ACC_WIDTH=24.
module tb_pe_column_n;

    localparam int NP = 3;
    localparam int DW = 8;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rest;
    logic          w_load;
    logic [DW-1:0] w_data;
    logic          w_err;
    logic          ready;
    logic          valid;
    logic [NP*DW-1:0] fmap;
    logic [AW-1:0] psum_in;
    logic          o_valid;
    logic [AW-1:0] o_psum;
    logic          busy;

    typedef struct {
        logic [AW-1:0] psum;
        int            due;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_column_n #(.NUM_PE(NP), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_rest  (rest),
        .i_w_load(w_load),
        .i_w_data(w_data),
        .o_w_err (w_err),
        .o_ready (ready),
        .i_valid (valid),
        .i_fmap  (fmap),
        .i_psum  (psum_in),
        .o_valid (o_valid),
        .o_psum  (o_psum),
        .o_busy  (busy)
    );

    // Monitor: every o_valid pops one expected result and checks value and cycle.
    always @(negedge clk) begin
        if (o_valid) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid cyc=%0d got psum=%0d want no output",
                         cyc, $signed(o_psum));
            end else begin
                exp_t e;
                e = q.pop_front();
                if (o_psum !== e.psum || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL psum_out got %0d @cyc %0d want %0d @cyc %0d",
                             $signed(o_psum), cyc, $signed(e.psum), e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [AW-1:0] got,
                         input logic [AW-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
        w_load = 1'b1;
        w_data = a;
        step();
        check("ready_low_load1", AW'(ready), 0);
        w_data = b;
        step();
        check("ready_low_load2", AW'(ready), 0);
        w_data = c;
        step();
        w_load = 1'b0;
        check("ready_after_load", AW'(ready), 1);
    endtask

    // Drive one vector for the next edge; push the expected result if accepted.
    task automatic send(input logic [DW-1:0] f0, input logic [DW-1:0] f1,
                        input logic [DW-1:0] f2, input logic [AW-1:0] p,
                        input logic [AW-1:0] want, input bit expect_out);
        exp_t e;
        valid   = 1'b1;
        fmap    = {f2, f1, f0};
        psum_in = p;
        if (expect_out) begin
            e.psum = want;
            e.due  = cyc + 1 + NP;
            q.push_back(e);
        end
        step();
        valid = 1'b0;
    endtask

    initial begin
        int budget;
        rest    = 1'b1;
        w_load  = 1'b0;
        w_data  = '0;
        valid   = 1'b0;
        fmap    = '0;
        psum_in = '0;
        idle(2);
        check("rst_psum", o_psum, 0);
        check("rst_valid", AW'(o_valid), 0);
        check("rst_ready", AW'(ready), 0);
        check("rst_busy", AW'(busy), 0);
        check("rst_err", AW'(w_err), 0);
        rest = 1'b0;
        step();

        // Scenario 1: load 1,2,3 then 10 + 4 + 10 + 18.
        load3(8'd1, 8'd2, 8'd3);
        send(8'd4, 8'd5, 8'd6, 24'd10, 24'd42, 1'b1);
        check("busy_inflight", AW'(busy), 1);

        // Scenario 2: back-to-back vectors.
        valid = 1'b1;
        send(8'd1, 8'd1, 8'd1, 24'd0, 24'd6, 1'b1);
        send(8'd2, 8'd2, 8'd2, 24'd0, 24'd12, 1'b1);
        send(8'd0, 8'd0, 8'hFF, 24'd0, 24'hFFFFFD, 1'b1);
        idle(6);
        check("busy_drained", AW'(busy), 0);
        check("psum_hold", o_psum, 24'hFFFFFD);

        // Scenario 3: extreme products then wraparound.
        load3(8'h80, 8'h80, 8'h80);
        send(8'h80, 8'h80, 8'h80, 24'd0, 24'd49152, 1'b1);
        idle(5);
        load3(8'd1, 8'd0, 8'd0);
        send(8'd1, 8'd0, 8'd0, 24'h7FFFFF, 24'h800000, 1'b1);
        idle(5);

        // Scenario 4: reload rejected while busy and when colliding with a vector.
        load3(8'd1, 8'd2, 8'd3);
        send(8'd4, 8'd5, 8'd6, 24'd10, 24'd42, 1'b1);
        w_load = 1'b1;
        w_data = 8'd7;
        step();
        w_load = 1'b0;
        check("err_busy_pulse", AW'(w_err), 1);
        check("ready_kept", AW'(ready), 1);
        step();
        check("err_one_cycle", AW'(w_err), 0);
        idle(4);
        w_load = 1'b1;
        w_data = 8'd7;
        send(8'd1, 8'd1, 8'd1, 24'd0, 24'd6, 1'b1);
        w_load = 1'b0;
        check("err_collide", AW'(w_err), 1);
        check("ready_collide", AW'(ready), 1);
        idle(5);

        // Scenario 5: vectors ignored before READY, reset flushes in-flight work.
        rest = 1'b1;
        step();
        rest = 1'b0;
        check("rst2_ready", AW'(ready), 0);
        send(8'd1, 8'd1, 8'd1, 24'd5, 24'd0, 1'b0);
        w_load = 1'b1;
        w_data = 8'd1;
        step();
        w_load = 1'b0;
        send(8'd1, 8'd1, 8'd1, 24'd5, 24'd0, 1'b0);
        check("loading_not_ready", AW'(ready), 0);
        w_load = 1'b1;
        w_data = 8'd2;
        step();
        w_data = 8'd3;
        step();
        w_load = 1'b0;
        check("ready_s5", AW'(ready), 1);
        send(8'd9, 8'd9, 8'd9, 24'd1, 24'd0, 1'b0);
        rest = 1'b1;
        step();
        rest = 1'b0;
        check("rst3_psum", o_psum, 0);
        check("rst3_valid", AW'(o_valid), 0);
        check("rst3_ready", AW'(ready), 0);
        check("rst3_busy", AW'(busy), 0);
        check("rst3_err", AW'(w_err), 0);
        idle(6);
        check("rst3_psum_late", o_psum, 0);

        // Scenario 6: fresh load 3,2,1 -> 12 + 10 + 6.
        load3(8'd3, 8'd2, 8'd1);
        send(8'd4, 8'd5, 8'd6, 24'd0, 24'd28, 1'b1);

        budget = 50;
        while (q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
